serial_byte_tx: RTL and testbench
=================================

Name: serial_byte_tx

Overview:
- Parallel-in, serial-out transmitter. Sits directly upstream of the 8-bit serial-in shift register.
- Accepts one word via a valid/ready handshake and drives it MSB-first onto a single serial line, one bit per clk.
- Pulses done in the cycle the downstream shift register holds the complete word in original bit order, so out[7:0] equals the word sent.

Parameters:
- WIDTH, 8, bits per frame; must be at least 2.
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream; feeds the shift register's "in".
- ser_active  output  1  high while ser_out carries a frame bit.
- done  output  1  one-cycle pulse: downstream register now holds the full frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values, applied on the first edge with reset high:
  - state=IDLE, ser_out=0, ser_active=0, done=0, shift register=0, counter=0.
  - load_ready is 0 while reset is high.
- FSM states: IDLE, SHIFT, DONE (and PAR with PARITY_EN).
- load_ready = (state==IDLE || state==DONE) && !reset. It is combinational from state.
- Accept when load_valid && load_ready at edge k:
  - shreg <= data_in << 1
  - ser_out <= data_in[WIDTH-1]
  - ser_active <= 1
  - cnt <= 0
  - state <= SHIFT
- In SHIFT, each edge:
  - ser_out <= shreg[WIDTH-1]
  - shreg <= shreg << 1
  - cnt <= cnt+1
- When cnt==WIDTH-1 at the edge: ser_out <= 0, ser_active <= 0, done <= 1, state <= DONE.
- Timing:
  - Bit i (MSB first) is on ser_out during cycle k+1+i.
  - ser_active is high for exactly WIDTH cycles (k+1 .. k+WIDTH).
  - done is high in cycle k+WIDTH+1 only.
- DONE lasts one cycle. Next state is SHIFT on a new accept, else IDLE.
- Back-to-back frames:
  - Accepting in DONE gives ser_active low for exactly one cycle between frames.
  - Frame period is WIDTH+1 cycles.
- load_valid and data_in are ignored in SHIFT. Changes to data_in after acceptance do not affect the frame.
- ser_out is 0 whenever ser_active is 0 (idle line low).
- Reset mid-frame: the frame is aborted. Outputs take reset values on the next edge, no done is generated, and no partial bits follow.
- reset and load_valid in the same cycle: reset wins and the word is not accepted.

Optional Feature:
- Macro: SERIAL_BYTE_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PAR for one cycle with ser_out = ^data (even parity over the captured word) and ser_active = 1.
  - ser_active is high WIDTH+1 cycles.
  - done is high in cycle k+WIDTH+2.
  - The parity bit is captured from data_in at accept.
- Undefined: no PAR state and no parity register. Timing is exactly as in Behaviour.

Decomposition:
- Shared package serial_pkg:
  - State encoding localparams: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2, S_PAR=2'd3.
  - Default frame width constant FRAME_W=8.
- One natural sub-module: bit_counter.
  - Synchronous clear and enable, CNT_W wide.
  - Asserts last when count==WIDTH-1.
- The FSM and shift register remain in serial_byte_tx.

Test Plan:
- Reset then idle: hold reset for 2 cycles, release, load_valid=0 -> ser_out=0, ser_active=0, done=0, load_ready=1 from the first cycle after release.
- Single frame: data_in=8'hA5 accepted at edge k -> ser_out=1,0,1,0,0,1,0,1 in cycles k+1..k+8; done=1 only in k+9; downstream register out=8'hA5 in k+9.
- Back-to-back: 8'hFF then 8'h00 with load_valid held high -> second accept in the DONE cycle; ser_active low exactly one cycle between frames; downstream shows 8'hFF then 8'h00 at the respective done pulses.
- Ignore during SHIFT: accept 8'h3C, then toggle data_in=8'hC3 with load_valid=1 mid-frame -> load_ready=0, stream remains 0,0,1,1,1,1,0,0, no second frame starts before DONE.
- Reset mid-frame: accept 8'h81, assert reset in cycle k+4 -> next cycle ser_out=0, ser_active=0, done never pulses for that frame, load_ready=1 after reset drops.
- Parity (SERIAL_BYTE_TX_PARITY_EN defined): 8'h07 -> data bits, then parity bit 1 in cycle k+9, done in k+10. For 8'h03 the parity bit is 0.

Source files
------------

// File: rtl/serial_byte_tx_pkg.sv
// Shared definitions for the serial byte transmitter: FSM state encoding and default frame width.
package serial_pkg;

    localparam int FRAME_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_PAR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE,
        PAR   = S_PAR
    } state_e;

endpackage

// File: rtl/serial_byte_tx_bit_counter.sv
// Frame bit counter: synchronous clear and enable, flags the last bit position of a frame.
module bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign last_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_byte_tx.sv
// Parallel-in, serial-out MSB-first transmitter feeding a downstream serial-in shift register.
// Optional even parity bit after the data bits when SERIAL_BYTE_TX_PARITY_EN is defined.
//
// state | meaning
// IDLE  | line low, ready for a word
// SHIFT | data bits on ser_out, one per clk
// PAR   | parity bit on ser_out (parity build only)
// DONE  | done pulse; may accept the next word
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = FRAME_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             ser_out_q;
    logic             ser_active_q;
    logic             done_q;
    logic             accept;
    logic             cnt_last;
`ifdef SERIAL_BYTE_TX_PARITY_EN
    logic             par_q;
`endif

    assign load_ready = ((state_q == IDLE) || (state_q == DONE)) && !reset;
    assign accept     = load_valid && load_ready;

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .clr_i  (reset || accept),
        .en_i   (state_q == SHIFT),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            ser_out_q    <= 1'b0;
            ser_active_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        // MSB goes straight to the line; the rest waits in the shifter
                        shreg_q      <= {data_in[WIDTH-2:0], 1'b0};
                        ser_out_q    <= data_in[WIDTH-1];
                        ser_active_q <= 1'b1;
                        state_q      <= SHIFT;
`ifdef SERIAL_BYTE_TX_PARITY_EN
                        par_q        <= ^data_in;
`endif
                    end else begin
                        ser_out_q    <= 1'b0;
                        ser_active_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    if (cnt_last) begin
`ifdef SERIAL_BYTE_TX_PARITY_EN
                        ser_out_q    <= par_q;
                        state_q      <= PAR;
`else
                        ser_out_q    <= 1'b0;
                        ser_active_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
`endif
                    end else begin
                        ser_out_q <= shreg_q[WIDTH-1];
                    end
                end
`ifdef SERIAL_BYTE_TX_PARITY_EN
                PAR: begin
                    ser_out_q    <= 1'b0;
                    ser_active_q <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= DONE;
                end
`endif
                default: begin
                    ser_out_q    <= 1'b0;
                    ser_active_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_active = ser_active_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Self-checking bench for serial_byte_tx: vector table, cycle-exact stream checks and a
// scoreboard that compares a model of the downstream shift register at every done pulse.
module tb_serial_byte_tx;

    localparam int W = 8;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    typedef struct {
        logic [7:0] ds;
        logic       par;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       ser_out;
    logic       ser_active;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ds_q = 8'h00;
    logic       acc = 1'b0;
    sb_t        sb_q[$];
    vec_t       vecs[8];

    serial_byte_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .done       (done)
    );

    always #5 clk = ~clk;

    // downstream serial-in shift register
    always @(posedge clk) ds_q <= {ds_q[W-2:0], ser_out};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic par);
        sb_t e;
`ifdef SERIAL_BYTE_TX_PARITY_EN
        e.ds = {d[W-2:0], par};
`else
        e.ds = d;
`endif
        e.par = par;
        sb_q.push_back(e);
    endtask

    // scoreboard: idle line low, and downstream contents/parity at each done pulse
    always @(negedge clk) begin
        sb_t e;
        if (ser_active === 1'b0) check("idle_line_low", ser_out, 0);
        if (reset) begin
            acc = 1'b0;
        end else if (done === 1'b1) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("downstream_word", ds_q, e.ds);
`ifdef SERIAL_BYTE_TX_PARITY_EN
                check("frame_even", acc, 0);
`else
                check("stream_parity", acc, e.par);
`endif
            end
            acc = 1'b0;
        end else if (ser_active === 1'b1) begin
            acc = acc ^ ser_out;
        end
    end

    task automatic run_frame(input logic [7:0] d, input logic par, input bit noise);
        data_in    = d;
        load_valid = 1'b1;
        #1;
        check("ready_before_accept", load_ready, 1);
        if (load_ready) push(d, par);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = ~d;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("data_bit", ser_out, d[W-1-i]);
            check("active_in_frame", ser_active, 1);
            check("no_done_in_frame", done, 0);
            check("busy_not_ready", load_ready, 0);
            if (noise && i == 2) begin
                data_in    = 8'hC3;
                load_valid = 1'b1;
            end
            if (noise && i == W-1) load_valid = 1'b0;
        end
`ifdef SERIAL_BYTE_TX_PARITY_EN
        @(negedge clk);
        check("parity_bit", ser_out, par);
        check("active_parity", ser_active, 1);
        check("no_done_parity", done, 0);
`endif
        @(negedge clk);
        check("done_pulse", done, 1);
        check("active_gap", ser_active, 0);
        check("ready_in_done", load_ready, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_idle", load_ready, 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h81, 1'b0};
        vecs[2] = '{8'h07, 1'b1};
        vecs[3] = '{8'h03, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'h01, 1'b1};
        vecs[7] = '{8'h7E, 1'b0};

        // reset held two cycles with a word offered: must not be accepted
        load_valid = 1'b1;
        data_in    = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", load_ready, 0);
        check("rst_ser_out", ser_out, 0);
        check("rst_active", ser_active, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", load_ready, 1);
        check("post_rst_active", ser_active, 0);
        check("post_rst_done", done, 0);

        for (int v = 0; v < 8; v++) run_frame(vecs[v].data, vecs[v].par, 1'b0);

        // data_in/load_valid changes during a frame are ignored
        run_frame(8'h3C, 1'b0, 1'b1);

        // back-to-back: FF then 00 with load_valid held high
        data_in    = 8'hFF;
        load_valid = 1'b1;
        #1;
        check("b2b_ready1", load_ready, 1);
        if (load_ready) push(8'hFF, 1'b0);
        @(posedge clk);
        #1;
        data_in = 8'h00;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("b2b_bit1", ser_out, 1);
            check("b2b_active1", ser_active, 1);
            check("b2b_busy1", load_ready, 0);
        end
`ifdef SERIAL_BYTE_TX_PARITY_EN
        @(negedge clk);
        check("b2b_par1", ser_out, 0);
`endif
        @(negedge clk);
        check("b2b_done1", done, 1);
        check("b2b_gap", ser_active, 0);
        check("b2b_ready2", load_ready, 1);
        if (load_ready) push(8'h00, 1'b0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("b2b_bit2", ser_out, 0);
            check("b2b_active2", ser_active, 1);
        end
`ifdef SERIAL_BYTE_TX_PARITY_EN
        @(negedge clk);
        check("b2b_active_par2", ser_active, 1);
`endif
        @(negedge clk);
        check("b2b_done2", done, 1);
        @(negedge clk);
        check("b2b_done2_end", done, 0);

        // reset mid-frame aborts: no done, line low afterwards
        data_in    = 8'h81;
        load_valid = 1'b1;
        #1;
        check("abort_ready", load_ready, 1);
        if (load_ready) push(8'h81, 1'b0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_ready_in_rst", load_ready, 0);
        check("abort_still_active", ser_active, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ser_out", ser_out, 0);
        check("abort_active", ser_active, 0);
        check("abort_ready_after", load_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_active", ser_active, 0);
        end

        run_frame(8'hA5, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
